fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_pkg.sv | 29 ++
 rtl/fetch_perf_counter.sv | 29 ++
 rtl/fetch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   - fetchState_e : sequencer state (idle after reset, running, halted on fault)
//   - InstrBytes   : instruction size in bytes, also the sequential PC step
//   - OpJ/OpJal/OpBne : opcodes of the instructions that drive redirects
//   - addrLegal()  : word-aligned and inside the instruction memory
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } fetchState_e;

    localparam int unsigned InstrBytes = 4;

    // Addresses are widened to this width before the legality compare.
    localparam int unsigned AddrCheckW = 64;

    localparam logic [5:0] OpJ   = 6'b000010;
    localparam logic [5:0] OpJal = 6'b000011;
    localparam logic [5:0] OpBne = 6'b000101;

    // Legal fetch address: aligned to a word and no higher than the last word.
    function automatic logic addrLegal(input logic [AddrCheckW-1:0] addr,
                                       input logic [AddrCheckW-1:0] memBytes);
        return (addr[1:0] == 2'b00) && (addr <= memBytes - AddrCheckW'(InstrBytes));
    endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter used for fetch statistics.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (count clears to 0)
//   inc        : count one event this cycle
//   count      : current value, sticks at all-ones
module fetch_perf_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [Width-1:0] count
);

    logic [Width-1:0] countQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countQ <= '0;
        end else if (inc && (countQ != '1)) begin
            countQ <= countQ + Width'(1);
        end
    end

    assign count = countQ;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the single-cycle core.
// Owns the PC, reads a combinational instruction memory and registers the word into a
// one-entry valid/ready output slot. Redirects flush the slot and reload the PC; an
// illegal redirect target or running off the end of memory raises a sticky fault and
// halts fetch until reset.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   mem_addr / mem_instr             : memory read address (= pc) and returned word
//   redirect_valid / redirect_target : jump/branch/jr redirect request
//   stall                            : freeze fetch
//   inst_valid/inst/inst_pc/inst_pc_plus4, inst_ready : output slot handshake
//   fault / fault_addr               : sticky illegal-address flag and offending address
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count and redirect_count outputs.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       MEM_BYTES = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              stall,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc_plus4,
    input  logic              inst_ready,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       redirect_count
`endif
);

    fetchState_e stateQ, stateD;

    logic [ADDR_W-1:0] pcQ;
    logic              instValidQ;
    logic [31:0]       instQ;
    logic [ADDR_W-1:0] instPcQ;
    logic [ADDR_W-1:0] instPcPlus4Q;
    logic              faultQ;
    logic [ADDR_W-1:0] faultAddrQ;
    // The word at pc has been captured but pc+4 is outside memory, so the next
    // sequential step is the one that faults.
    logic              atEndQ;

    logic [ADDR_W-1:0] seqNext;
    logic              seqLegal;
    logic              redirectLegal;
    logic              slotFree;
    logic              takeRedirect;
    logic              redirectFault;
    logic              seqFault;
    logic              capture;
    logic              drain;
    logic              faultNow;

    assign seqNext       = pcQ + ADDR_W'(InstrBytes);
    assign seqLegal      = addrLegal(AddrCheckW'(seqNext), AddrCheckW'(MEM_BYTES));
    assign redirectLegal = addrLegal(AddrCheckW'(redirect_target), AddrCheckW'(MEM_BYTES));
    assign slotFree      = !instValidQ || inst_ready;
    assign faultNow      = redirectFault || seqFault;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  stateD = StRun;
            StRun:   if (faultNow) stateD = StHalt;
            StHalt:  stateD = StHalt;
            default: stateD = StIdle;
        endcase
    end

    // Per-cycle action decode; redirect outranks stall and the handshake.
    always_comb begin
        takeRedirect  = 1'b0;
        redirectFault = 1'b0;
        seqFault      = 1'b0;
        capture       = 1'b0;
        drain         = 1'b0;
        if (stateQ == StRun) begin
            if (redirect_valid) begin
                takeRedirect  = redirectLegal;
                redirectFault = !redirectLegal;
            end else if (slotFree) begin
                if (stall) begin
                    drain = 1'b1;
                end else if (atEndQ) begin
                    seqFault = 1'b1;
                end else begin
                    capture = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcQ          <= RESET_PC;
            instValidQ   <= 1'b0;
            instQ        <= '0;
            instPcQ      <= '0;
            instPcPlus4Q <= ADDR_W'(InstrBytes);
            faultQ       <= 1'b0;
            faultAddrQ   <= '0;
            atEndQ       <= 1'b0;
        end else if (takeRedirect) begin
            pcQ        <= redirect_target;
            instValidQ <= 1'b0;
            atEndQ     <= 1'b0;
        end else if (faultNow) begin
            // pc is left alone so it never points outside memory.
            faultQ     <= 1'b1;
            faultAddrQ <= redirectFault ? redirect_target : seqNext;
            instValidQ <= 1'b0;
        end else if (capture) begin
            instQ        <= mem_instr;
            instPcQ      <= pcQ;
            instPcPlus4Q <= seqNext;
            instValidQ   <= 1'b1;
            if (seqLegal) begin
                pcQ <= seqNext;
            end else begin
                atEndQ <= 1'b1;
            end
        end else if (drain) begin
            instValidQ <= 1'b0;
        end
    end

    assign mem_addr      = pcQ;
    assign inst_valid    = instValidQ;
    assign inst          = instQ;
    assign inst_pc       = instPcQ;
    assign inst_pc_plus4 = instPcPlus4Q;
    assign fault         = faultQ;
    assign fault_addr    = faultAddrQ;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter #(
        .Width (32)
    ) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (capture),
        .count (fetch_count)
    );

    fetch_perf_counter #(
        .Width (32)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (takeRedirect),
        .count (redirect_count)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a fetch-cursor reference model checked every
// falling edge, plus hand-computed expectations along the directed sequence.
module tb_fetch_sequencer;

    localparam int unsigned MEM_BYTES = 32;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        inst_ready;
    logic        fault;
    logic [31:0] fault_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    int checks = 0;
    int errors = 0;

    // ori $1,$0,5 / jal 24 / j 8, then distinct filler words.
    logic [31:0] progMem [8];
    initial begin
        progMem[0] = 32'h3401_0005;
        progMem[1] = 32'h0C00_0006;
        progMem[2] = 32'h0800_0002;
        for (int i = 3; i < 8; i++) progMem[i] = 32'hA000_0000 + 32'(i);
    end

    assign mem_instr = (mem_addr < MEM_BYTES) ? progMem[mem_addr[4:2]] : 32'hDEAD_BEEF;

    fetch_sequencer #(
        .ADDR_W    (32),
        .RESET_PC  (32'd0),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_addr        (mem_addr),
        .mem_instr       (mem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_pc_plus4   (inst_pc_plus4),
        .inst_ready      (inst_ready),
        .fault           (fault),
        .fault_addr      (fault_addr)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .redirect_count  (redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a fetch cursor naming the next word to fetch. The cursor may
    // step past the last word; the PC shown to memory is then the last legal word.
    function automatic bit legalFetch(input logic [31:0] a);
        return (a % 4 == 0) && (longint'(a) + 4 <= longint'(MEM_BYTES));
    endfunction

    int          mPhase;  // 0 settling after reset, 1 fetching, 2 halted
    logic [31:0] mCursor;
    bit          mValid;
    logic [31:0] mInst;
    logic [31:0] mInstPc;
    bit          mFault;
    logic [31:0] mFaultAddr;
    int          mFetchCnt;
    int          mRedirCnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase     <= 0;
            mCursor    <= 32'd0;
            mValid     <= 1'b0;
            mInst      <= 32'd0;
            mInstPc    <= 32'd0;
            mFault     <= 1'b0;
            mFaultAddr <= 32'd0;
            mFetchCnt  <= 0;
            mRedirCnt  <= 0;
        end else if (mPhase == 0) begin
            mPhase <= 1;
        end else if (mPhase == 1) begin
            if (redirect_valid) begin
                mValid <= 1'b0;
                if (legalFetch(redirect_target)) begin
                    mCursor   <= redirect_target;
                    mRedirCnt <= mRedirCnt + 1;
                end else begin
                    mFault     <= 1'b1;
                    mFaultAddr <= redirect_target;
                    mPhase     <= 2;
                end
            end else if (!mValid || inst_ready) begin
                if (stall) begin
                    mValid <= 1'b0;
                end else if (!legalFetch(mCursor)) begin
                    mValid     <= 1'b0;
                    mFault     <= 1'b1;
                    mFaultAddr <= mCursor;
                    mPhase     <= 2;
                end else begin
                    mValid    <= 1'b1;
                    mInst     <= progMem[mCursor[4:2]];
                    mInstPc   <= mCursor;
                    mCursor   <= mCursor + 32'd4;
                    mFetchCnt <= mFetchCnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("mem_addr", mem_addr, legalFetch(mCursor) ? mCursor : mCursor - 32'd4);
        check("inst_valid", 32'(inst_valid), 32'(mValid));
        check("inst", inst, mInst);
        check("inst_pc", inst_pc, mInstPc);
        check("inst_pc_plus4", inst_pc_plus4, mInstPc + 32'd4);
        check("fault", 32'(fault), 32'(mFault));
        check("fault_addr", fault_addr, mFaultAddr);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'(mFetchCnt));
        check("redirect_count", redirect_count, 32'(mRedirCnt));
`endif
    end

    initial begin
        bit found;
        rst_n           = 1'b0;
        inst_ready      = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        tick();
        tick();
        check("rst inst_valid", 32'(inst_valid), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst inst_pc_plus4", inst_pc_plus4, 32'd4);
        check("rst fault", 32'(fault), 32'd0);

        rst_n = 1'b1;
        tick();
        check("idle no capture", 32'(inst_valid), 32'd0);
        tick();
        check("first valid", 32'(inst_valid), 32'd1);
        check("first inst_pc", inst_pc, 32'd0);
        check("first inst", inst, 32'h3401_0005);
        tick();
        check("second inst_pc", inst_pc, 32'd4);

        // Back-pressure: slot and pc hold for three cycles.
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold inst_pc", inst_pc, 32'd4);
            check("hold inst", inst, 32'h0C00_0006);
            check("hold mem_addr", mem_addr, 32'd8);
        end
        inst_ready = 1'b1;
        tick();
        check("after ready inst_pc", inst_pc, 32'd8);

        // Return to 4, then redirect to 24 while the slot holds pc=4.
        redirect_valid  = 1'b1;
        redirect_target = 32'd4;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("back at 4", inst_pc, 32'd4);
        redirect_valid  = 1'b1;
        redirect_target = 32'd24;
        tick();
        redirect_valid = 1'b0;
        check("redirect flush", 32'(inst_valid), 32'd0);
        check("redirect pc", mem_addr, 32'd24);
        tick();
        check("target valid", 32'(inst_valid), 32'd1);
        check("target inst_pc", inst_pc, 32'd24);
        check("target plus4", inst_pc_plus4, 32'd28);
        check("target inst", inst, 32'hA000_0006);

        // Redirect beats stall.
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'd8;
        tick();
        redirect_valid = 1'b0;
        check("stall redirect flush", 32'(inst_valid), 32'd0);
        check("stall redirect pc", mem_addr, 32'd8);
        tick();
        check("stalled empty", 32'(inst_valid), 32'd0);
        stall = 1'b0;
        tick();
        check("after stall inst_pc", inst_pc, 32'd8);

        // Drain while stalled.
        stall = 1'b1;
        tick();
        check("drain", 32'(inst_valid), 32'd0);
        check("drain pc hold", mem_addr, 32'd12);
        stall = 1'b0;

        // Sequential fetch to the last word.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (inst_valid && inst_pc == 32'd28) found = 1'b1;
        end
        check("reached pc 28", 32'(found), 32'd1);
        tick();
        check("end fault", 32'(fault), 32'd1);
        check("end fault_addr", fault_addr, 32'd32);
        check("end inst_valid", 32'(inst_valid), 32'd0);
        tick();
        check("halt inst_valid", 32'(inst_valid), 32'd0);
        check("halt pc", mem_addr, 32'd28);

        rst_n = 1'b0;
        #1;
        check("async clear fault", 32'(fault), 32'd0);
        check("async clear valid", 32'(inst_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Illegal redirect alongside a legal sequential step.
        redirect_valid  = 1'b1;
        redirect_target = 32'd6;
        tick();
        redirect_valid = 1'b0;
        check("bad target fault", 32'(fault), 32'd1);
        check("bad target addr", fault_addr, 32'd6);
        check("bad target valid", 32'(inst_valid), 32'd0);
        check("bad target pc", mem_addr, 32'd4);
        tick();
        check("bad target sticky", 32'(fault), 32'd1);

        rst_n = 1'b0;
        #1;
        check("async clear fault 2", 32'(fault), 32'd0);
        check("async clear fault_addr", fault_addr, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
